mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage RV32I pipeline. It consumes the EX/MEM pipeline register (`ex_mem_t`), issues at most one data-memory request per instruction, and stalls upstream until the response returns. It aligns and sign- or zero-extends load data, then registers the result into the MEM/WB pipeline register (`mem_wb_t`). It also exports a forwarding bundle (`fwd_t`) taken from that register.

## Interface
- No parameters; all widths are fixed by `rv32i_types`.
- `clk  in  1` — pipeline clock; all state updates on the rising edge.
- `rst_n  in  1` — asynchronous, active-low reset.
- `ex_mem  in  ex_mem_t` — EX/MEM register contents; upstream holds it stable while `mem_stall` is 1.
- `dmem_addr  out  32` — word-aligned address: `{ex_mem.dmem_addr[31:2], 2'b00}`.
- `dmem_rmask  out  4` — read byte mask; nonzero for exactly one cycle per load.
- `dmem_wmask  out  4` — write byte mask; nonzero for exactly one cycle per store.
- `dmem_wdata  out  32` — store data, pre-shifted by EX (`ex_mem.dmem_wdata`).
- `dmem_rdata  in  32` — read data; valid only when `dmem_resp` is 1.
- `dmem_resp  in  1` — one-cycle response pulse; never arrives in the same cycle as the request.
- `mem_stall  out  1` — freezes IF, ID, EX and the EX/MEM register.
- `mem_wb  out  mem_wb_t` — registered MEM/WB register.
- `mem_fwd  out  fwd_t` — `{mem_wb.rd_s, mem_wb.rd_v, mem_wb.regf_we & mem_wb.valid}`.

## Operation
- **Memory op:** `mem_op = ex_mem.valid & (|ex_mem.dmem_rmask | |ex_mem.dmem_wmask)`.
- **FSM states:** `MEM_IDLE` and `MEM_WAIT`.
- **MEM_IDLE, `mem_op`:**
  - Drive `dmem_rmask` and `dmem_wmask` from `ex_mem` (one cycle only).
  - Set `mem_stall=1`.
  - Go to `MEM_WAIT`.
  - Load `mem_wb.valid=0` (bubble).
- **MEM_IDLE, `!mem_op`:**
  - Masks are 0 and `mem_stall=0`.
  - Load `mem_wb` from `ex_mem`: `rd_v` passes through; `dmem_rdata=0`.
  - `valid` follows `ex_mem.valid`.
- **MEM_WAIT, `!dmem_resp`:**
  - Masks are 0 and `mem_stall=1`.
  - Load `mem_wb.valid=0`.
- **MEM_WAIT, `dmem_resp`:**
  - `mem_stall=0`.
  - Load `mem_wb` from `ex_mem` with `valid=1` and `dmem_rdata=dmem_rdata`.
  - For a load, `rd_v` is the aligned value; for a store, `rd_v` passes through.
  - Go to `MEM_IDLE`.
- **Load alignment:** `off=ex_mem.dmem_addr[1:0]`, selected by `ex_mem.funct3`.
  - lb: sign-extend `rdata[8*off +: 8]`; lbu zero-extends the same byte.
  - lh: sign-extend `rdata[16*off[1] +: 16]`; lhu zero-extends the same half.
  - lw: pass `rdata` unchanged.
  - Any other `funct3` yields 0.
- **mem_wb field copy:** `dmem_wmask`, `dmem_rmask`, `dmem_wdata`, `dmem_addr` (unaligned original), `pc`, `pc_next`, `inst`, `rs1_s`, `rs2_s`, `rs1_v`, `rs2_v`, `rd_s`, `regf_we` are copied from `ex_mem`.
- **Stray response:** a `dmem_resp` that arrives in `MEM_IDLE` is ignored.
- **Misaligned accesses:** not detected; EX guarantees alignment.

## Timing
- **Reset (`rst_n=0`, async):**
  - State returns to `MEM_IDLE`; every `mem_wb` field becomes 0, so `mem_fwd` is all 0.
  - While reset is held, masks and `mem_stall` are also 0.
- **Non-memory instruction:** 1-cycle latency; `mem_wb` updates at the next edge.
- **Memory op:** request in cycle T; response at T+N, N≥1.
  - `mem_wb` valid after edge T+N.
  - `mem_stall` is high for cycles T..T+N-1.
- **Back-to-back memory ops:** the next op issues in the cycle after the response; minimum 2 cycles per memory op.
- **Reset mid-WAIT:** the outstanding request is abandoned and its late response is ignored (it arrives in `MEM_IDLE`).
- **Combinational outputs:** `dmem_*` outputs and `mem_stall` are combinational from state and `ex_mem`. There is no combinational path from `dmem_rdata` to `mem_stall`.

## Structure
- **Shared package:** add `typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t` to `rv32i_types`. Reuse `load_funct3_t`, `ex_mem_t`, `mem_wb_t`, `fwd_t`.
- **Sub-module:** `load_align` (combinational).
  - Inputs: `funct3`, `off[1:0]`, `rdata[31:0]`.
  - Output: `rd_v[31:0]`.
  - Instantiated once.

## Test plan
- **Reset:** assert `rst_n=0` mid-sim → `mem_wb`=0, `mem_stall`=0 and masks=0 immediately without a clock edge; deassert → state `MEM_IDLE`.
- **ALU pass-through:** `ex_mem` valid, masks 0, `rd_v=32'h1234_5678`, `rd_s=5` → next edge `mem_wb.valid=1`, `rd_v=32'h1234_5678`, `mem_fwd.rd_s=5`, `mem_stall` never high.
- **lb, 3-cycle latency:**
  - Stimulus: `addr=32'h100`, byte 3 selected, `rmask=4'b1000`, resp 3 cycles later with `rdata=32'h80AA_BBCC`.
  - Response: `rmask` high 1 cycle; `mem_stall` high 3 cycles; `rd_v=32'hFFFF_FF80`.
- **lhu:** `addr` off=2, `rdata=32'h8001_0002` → `rd_v=32'h0000_8001`. **lw:** same `rdata` → `rd_v=32'h8001_0002`.
- **sw then lw back-to-back, resp N=1 each:**
  - `wmask=4'hF` for 1 cycle, then `rmask=4'hF` 2 cycles after it.
  - Two valid `mem_wb` entries arrive 2 cycles apart, with a bubble between them.
- **Reset in WAIT, then stray resp:** `rst_n` pulse during `MEM_WAIT`, then `dmem_resp=1` in `MEM_IDLE` → no `mem_wb.valid`, no state change.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: load funct3 codes, MEM FSM states,
// and the EX/MEM, MEM/WB and forwarding bundles.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [4:0]  rd_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [31:0] rd_v;
        logic        regf_we;
        logic [2:0]  funct3;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [4:0]  rd_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [31:0] rd_v;
        logic        regf_we;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
        logic [31:0] dmem_rdata;
    } mem_wb_t;

    typedef struct packed {
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        we;
    } fwd_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks byte/half/word from a read word and
// sign- or zero-extends it. Ports: funct3, off, rdata in; rd_v out.
module load_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] rd_v
);

    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_b = rdata[{off, 3'b000} +: 8];
    assign w_h = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        rd_v = '0;
        case (load_funct3_t'(funct3))
            LB:      rd_v = {{24{w_b[7]}}, w_b};
            LBU:     rd_v = {24'h0, w_b};
            LH:      rd_v = {{16{w_h[15]}}, w_h};
            LHU:     rd_v = {16'h0, w_h};
            LW:      rd_v = rdata;
            default: rd_v = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one data-memory request per instruction, stall
// until response, align loads, register MEM/WB and export forwarding.
// Ports: clk, rst_n, ex_mem in; dmem_* request/response; mem_stall,
// mem_wb, mem_fwd out.
module mem_stage
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  ex_mem_t     ex_mem,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output mem_wb_t     mem_wb,
    output fwd_t        mem_fwd
);

    mem_state_t  r_state;
    mem_state_t  w_state_n;
    mem_wb_t     r_wb;
    mem_wb_t     w_wb_n;
    logic        w_mem_op;
    logic [31:0] w_ld_v;

    assign w_mem_op = ex_mem.valid &
                      (|ex_mem.dmem_rmask | |ex_mem.dmem_wmask);

    assign dmem_addr  = {ex_mem.dmem_addr[31:2], 2'b00};
    assign dmem_wdata = ex_mem.dmem_wdata;

    load_align u_align (
        .funct3 (ex_mem.funct3),
        .off    (ex_mem.dmem_addr[1:0]),
        .rdata  (dmem_rdata),
        .rd_v   (w_ld_v)
    );

    always_comb begin
        w_state_n  = r_state;
        dmem_rmask = '0;
        dmem_wmask = '0;
        mem_stall  = 1'b0;

        w_wb_n.valid      = ex_mem.valid;
        w_wb_n.pc         = ex_mem.pc;
        w_wb_n.pc_next    = ex_mem.pc_next;
        w_wb_n.inst       = ex_mem.inst;
        w_wb_n.rs1_s      = ex_mem.rs1_s;
        w_wb_n.rs2_s      = ex_mem.rs2_s;
        w_wb_n.rd_s       = ex_mem.rd_s;
        w_wb_n.rs1_v      = ex_mem.rs1_v;
        w_wb_n.rs2_v      = ex_mem.rs2_v;
        w_wb_n.rd_v       = ex_mem.rd_v;
        w_wb_n.regf_we    = ex_mem.regf_we;
        w_wb_n.dmem_addr  = ex_mem.dmem_addr;
        w_wb_n.dmem_rmask = ex_mem.dmem_rmask;
        w_wb_n.dmem_wmask = ex_mem.dmem_wmask;
        w_wb_n.dmem_wdata = ex_mem.dmem_wdata;
        w_wb_n.dmem_rdata = '0;

        unique case (r_state)
            MEM_IDLE: begin
                if (w_mem_op) begin
                    dmem_rmask   = ex_mem.dmem_rmask;
                    dmem_wmask   = ex_mem.dmem_wmask;
                    mem_stall    = 1'b1;
                    w_wb_n.valid = 1'b0;
                    w_state_n    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_resp) begin
                    w_wb_n.valid      = 1'b1;
                    w_wb_n.dmem_rdata = dmem_rdata;
                    if (|ex_mem.dmem_rmask) begin
                        w_wb_n.rd_v = w_ld_v;
                    end
                    w_state_n = MEM_IDLE;
                end else begin
                    mem_stall    = 1'b1;
                    w_wb_n.valid = 1'b0;
                end
            end
        endcase

        // Keep the memory port and the stall quiet while held in reset.
        if (!rst_n) begin
            dmem_rmask = '0;
            dmem_wmask = '0;
            mem_stall  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MEM_IDLE;
            r_wb    <= '0;
        end else begin
            r_state <= w_state_n;
            r_wb    <= w_wb_n;
        end
    end

    assign mem_wb       = r_wb;
    assign mem_fwd.rd_s = r_wb.rd_s;
    assign mem_fwd.rd_v = r_wb.rd_v;
    assign mem_fwd.we   = r_wb.regf_we & r_wb.valid;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized instruction stream with
// a transaction-level model, plus directed load/store/reset cases.
module tb_mem_stage;
    import rv32i_types::*;

    logic        clk;
    logic        rst_n;
    ex_mem_t     ex_mem;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    mem_wb_t     mem_wb;
    fwd_t        mem_fwd;

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_mem     (ex_mem),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_stall  (mem_stall),
        .mem_wb     (mem_wb),
        .mem_fwd    (mem_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          chk_en;
    logic        exp_stall;
    logic [3:0]  exp_rmask;
    logic [3:0]  exp_wmask;
    ex_mem_t     exp_e;
    mem_wb_t     exp_wb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req,
                     $time);
        end
    endtask

    // Reference alignment computed with plain shifts and arithmetic.
    function automatic logic [31:0] align(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic [31:0] d);
        logic [31:0] sh;
        logic [31:0] b;
        logic [31:0] h;
        sh = d >> (8 * off);
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic mem_wb_t mk_wb(input ex_mem_t e, input logic v,
                                      input logic [31:0] rdv,
                                      input logic [31:0] rdata);
        mem_wb_t w;
        w.valid      = v;
        w.pc         = e.pc;
        w.pc_next    = e.pc_next;
        w.inst       = e.inst;
        w.rs1_s      = e.rs1_s;
        w.rs2_s      = e.rs2_s;
        w.rd_s       = e.rd_s;
        w.rs1_v      = e.rs1_v;
        w.rs2_v      = e.rs2_v;
        w.rd_v       = rdv;
        w.regf_we    = e.regf_we;
        w.dmem_addr  = e.dmem_addr;
        w.dmem_rmask = e.dmem_rmask;
        w.dmem_wmask = e.dmem_wmask;
        w.dmem_wdata = e.dmem_wdata;
        w.dmem_rdata = rdata;
        return w;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
            chk("rmask", 32'(dmem_rmask), 32'(exp_rmask));
            chk("wmask", 32'(dmem_wmask), 32'(exp_wmask));
            if ((exp_rmask | exp_wmask) != 4'h0) begin
                chk("addr", dmem_addr, {exp_e.dmem_addr[31:2], 2'b00});
                chk("wdata", dmem_wdata, exp_e.dmem_wdata);
            end
            chk("wb.valid", 32'(mem_wb.valid), 32'(exp_wb.valid));
            chk("fwd.we", 32'(mem_fwd.we),
                32'(exp_wb.valid & exp_wb.regf_we));
            if (exp_wb.valid) begin
                chk("wb.rd_v", mem_wb.rd_v, exp_wb.rd_v);
                chk("wb.rd_s", 32'(mem_wb.rd_s), 32'(exp_wb.rd_s));
                chk("wb.rdata", mem_wb.dmem_rdata, exp_wb.dmem_rdata);
                chk("wb.pc", mem_wb.pc, exp_wb.pc);
                chk("wb.pc_next", mem_wb.pc_next, exp_wb.pc_next);
                chk("wb.inst", mem_wb.inst, exp_wb.inst);
                chk("wb.addr", mem_wb.dmem_addr, exp_wb.dmem_addr);
                chk("wb.wdata", mem_wb.dmem_wdata, exp_wb.dmem_wdata);
                chk("wb.masks", {mem_wb.dmem_rmask, mem_wb.dmem_wmask},
                    {exp_wb.dmem_rmask, exp_wb.dmem_wmask});
                chk("wb.srcs", {mem_wb.rs1_s, mem_wb.rs2_s, mem_wb.regf_we},
                    {exp_wb.rs1_s, exp_wb.rs2_s, exp_wb.regf_we});
                chk("wb.rs1_v", mem_wb.rs1_v, exp_wb.rs1_v);
                chk("wb.rs2_v", mem_wb.rs2_v, exp_wb.rs2_v);
                chk("fwd.rd_v", mem_fwd.rd_v, exp_wb.rd_v);
                chk("fwd.rd_s", 32'(mem_fwd.rd_s), 32'(exp_wb.rd_s));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction through MEM; n = response latency for memory ops.
    task automatic run_instr(input ex_mem_t e, input int n,
                             input logic [31:0] rd, input bit stray);
        bit mop;
        mop = e.valid && (e.dmem_rmask != 0 || e.dmem_wmask != 0);
        ex_mem = e;
        exp_e  = e;
        if (!mop) begin
            exp_stall  = 1'b0;
            exp_rmask  = 4'h0;
            exp_wmask  = 4'h0;
            dmem_resp  = stray;
            dmem_rdata = rd;
            step();
            dmem_resp = 1'b0;
            exp_wb = mk_wb(e, e.valid, e.rd_v, 32'h0);
        end else begin
            exp_stall = 1'b1;
            exp_rmask = e.dmem_rmask;
            exp_wmask = e.dmem_wmask;
            step();
            exp_rmask    = 4'h0;
            exp_wmask    = 4'h0;
            exp_wb.valid = 1'b0;
            for (int k = 1; k < n; k++) step();
            exp_stall  = 1'b0;
            dmem_resp  = 1'b1;
            dmem_rdata = rd;
            step();
            dmem_resp = 1'b0;
            exp_wb = mk_wb(e, 1'b1,
                           (e.dmem_rmask != 0) ?
                           align(e.funct3, e.dmem_addr[1:0], rd) : e.rd_v,
                           rd);
        end
    endtask

    function automatic ex_mem_t rand_em();
        ex_mem_t e;
        int      kind;
        logic [1:0] off;
        logic [2:0] f3s [6];
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
        e = '0;
        e.valid   = ($urandom_range(0, 9) != 0);
        e.pc      = $urandom;
        e.pc_next = $urandom;
        e.inst    = $urandom;
        e.rs1_s   = 5'($urandom);
        e.rs2_s   = 5'($urandom);
        e.rd_s    = 5'($urandom);
        e.rs1_v   = $urandom;
        e.rs2_v   = $urandom;
        e.rd_v    = $urandom;
        e.regf_we = 1'($urandom);
        e.dmem_wdata = $urandom;
        kind = $urandom_range(0, 2);
        off  = 2'($urandom);
        if (kind == 0) begin
            e.funct3    = 3'($urandom);
            e.dmem_addr = $urandom;
        end else if (kind == 1) begin
            e.funct3 = f3s[$urandom_range(0, 5)];
            case (e.funct3)
                3'd1, 3'd5: off = {off[1], 1'b0};
                3'd2:       off = 2'b00;
                default:    ;
            endcase
            case (e.funct3)
                3'd0, 3'd4: e.dmem_rmask = 4'b0001 << off;
                3'd1, 3'd5: e.dmem_rmask = 4'b0011 << off;
                default:    e.dmem_rmask = 4'hF;
            endcase
            e.dmem_addr = {30'($urandom), off};
        end else begin
            e.funct3 = 3'($urandom_range(0, 2));
            case (e.funct3)
                3'd0:    e.dmem_wmask = 4'b0001 << off;
                3'd1: begin
                    off = {off[1], 1'b0};
                    e.dmem_wmask = 4'b0011 << off;
                end
                default: begin
                    off = 2'b00;
                    e.dmem_wmask = 4'hF;
                end
            endcase
            e.dmem_addr = {30'($urandom), off};
        end
        return e;
    endfunction

    function automatic ex_mem_t mk_em(input logic [31:0] addr,
                                      input logic [2:0] f3,
                                      input logic [3:0] rm,
                                      input logic [3:0] wm,
                                      input logic [31:0] rdv,
                                      input logic [4:0] rds);
        ex_mem_t e;
        e = '0;
        e.valid      = 1'b1;
        e.pc         = 32'h0000_1000 + addr;
        e.pc_next    = 32'h0000_1004 + addr;
        e.inst       = 32'h0000_0013;
        e.rd_s       = rds;
        e.rd_v       = rdv;
        e.regf_we    = 1'b1;
        e.funct3     = f3;
        e.dmem_addr  = addr;
        e.dmem_rmask = rm;
        e.dmem_wmask = wm;
        e.dmem_wdata = 32'hDEAD_BEEF;
        return e;
    endfunction

    initial begin
        ex_mem_t e;
        chk_en     = 1'b0;
        rst_n      = 1'b0;
        ex_mem     = '0;
        dmem_rdata = '0;
        dmem_resp  = 1'b0;
        exp_stall  = 1'b0;
        exp_rmask  = 4'h0;
        exp_wmask  = 4'h0;
        exp_e      = '0;
        exp_wb     = '0;
        #3;
        chk("rst.wb_zero", 32'(mem_wb == '0), 32'd1);
        chk("rst.fwd_zero", 32'(mem_fwd == '0), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // ALU pass-through
        run_instr(mk_em(32'h0, 3'd0, 4'h0, 4'h0, 32'h1234_5678, 5'd5),
                  1, 32'h0, 1'b0);
        chk("alu.rd_v", mem_wb.rd_v, 32'h1234_5678);
        chk("alu.fwd_rd_s", 32'(mem_fwd.rd_s), 32'd5);

        // lb byte 3, 3-cycle response
        run_instr(mk_em(32'h103, 3'd0, 4'b1000, 4'h0, 32'h0, 5'd7),
                  3, 32'h80AA_BBCC, 1'b0);
        chk("lb.rd_v", mem_wb.rd_v, 32'hFFFF_FF80);

        // lhu off 2, lw
        run_instr(mk_em(32'h202, 3'd5, 4'b1100, 4'h0, 32'h0, 5'd8),
                  2, 32'h8001_0002, 1'b0);
        chk("lhu.rd_v", mem_wb.rd_v, 32'h0000_8001);
        run_instr(mk_em(32'h300, 3'd2, 4'hF, 4'h0, 32'h0, 5'd9),
                  1, 32'h8001_0002, 1'b0);
        chk("lw.rd_v", mem_wb.rd_v, 32'h8001_0002);

        // sw then lw back-to-back, N=1 each
        run_instr(mk_em(32'h400, 3'd2, 4'h0, 4'hF, 32'h5555_0000, 5'd10),
                  1, 32'h0, 1'b0);
        chk("sw.rd_v", mem_wb.rd_v, 32'h5555_0000);
        run_instr(mk_em(32'h400, 3'd2, 4'hF, 4'h0, 32'h0, 5'd11),
                  1, 32'hCAFE_F00D, 1'b0);
        chk("lw2.rd_v", mem_wb.rd_v, 32'hCAFE_F00D);

        // reset during WAIT, then a stray response in IDLE
        e = mk_em(32'h500, 3'd2, 4'hF, 4'h0, 32'h0, 5'd12);
        ex_mem    = e;
        exp_e     = e;
        exp_stall = 1'b1;
        exp_rmask = 4'hF;
        exp_wmask = 4'h0;
        step();
        exp_rmask    = 4'h0;
        exp_wb.valid = 1'b0;
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rstw.stall", 32'(mem_stall), 32'd0);
        chk("rstw.masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
        chk("rstw.wb_zero", 32'(mem_wb == '0), 32'd1);
        chk("rstw.fwd_zero", 32'(mem_fwd == '0), 32'd1);
        ex_mem = '0;
        step();
        rst_n = 1'b1;
        exp_e     = '0;
        exp_stall = 1'b0;
        exp_wb    = '0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h1111_2222;
        chk_en = 1'b1;
        step();
        dmem_resp = 1'b0;
        run_instr(mk_em(32'h0, 3'd0, 4'h0, 4'h0, 32'hABCD_0001, 5'd13),
                  1, 32'h0, 1'b0);
        chk("post_rst.rd_v", mem_wb.rd_v, 32'hABCD_0001);

        // randomized stream
        for (int i = 0; i < 300; i++) begin
            run_instr(rand_em(), $urandom_range(1, 4), $urandom,
                      1'($urandom_range(0, 3) == 0));
        end

        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
